// File: rtl/tetris_vga_pkg.sv
// Shared tile-store geometry and CPU address decode for the tetris VGA slice.
package tetris_vga_pkg;

  localparam int TILE_W      = 8;
  localparam int BOARD_COLS  = 10;
  localparam int BOARD_TILES = 200;
  localparam int NEXT_TILES  = 16;
  localparam int NEXT_BASE   = 200;
  localparam int STORE_TILES = BOARD_TILES + NEXT_TILES;

  typedef enum logic [1:0] {
    ADDR_BOARD,
    ADDR_NEXT,
    ADDR_INVALID
  } addr_kind_t;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } fill_state_t;

  function automatic addr_kind_t decode_addr(input logic [7:0] addr);
    if (int'(addr) < BOARD_TILES) begin
      return ADDR_BOARD;
    end else if (int'(addr) < NEXT_BASE + NEXT_TILES) begin
      return ADDR_NEXT;
    end else begin
      return ADDR_INVALID;
    end
  endfunction

endpackage

// File: rtl/vblank_strobe.sv
// Single-cycle per-frame strobe at the start of the configured blanking line.
module vblank_strobe #(
  parameter int VBLANK_LINE = 480
) (
  input  logic [10:0] hcnt,
  input  logic [9:0]  vcnt,
  output logic        trigger
);

  assign trigger = (hcnt == 11'd0) && (vcnt == 10'(VBLANK_LINE));

endmodule

// File: rtl/tile_update_ctrl.sv
// Shadow tile store with CPU writes, a board-fill engine and a once-per-frame
// tear-free commit of the shadow into the displayed tile vectors.
module tile_update_ctrl
  import tetris_vga_pkg::*;
#(
  parameter int VBLANK_LINE = 480
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [10:0]                     hcnt,
  input  logic [9:0]                      vcnt,
  input  logic                            wr_valid,
  input  logic [7:0]                      wr_addr,
  input  logic [7:0]                      wr_data,
  output logic                            wr_ready,
  output logic                            wr_err,
  input  logic                            fill_req,
  input  logic [7:0]                      fill_data,
  output logic                            fill_busy,
  input  logic                            commit_req,
  output logic                            commit_pending,
  output logic                            commit_done,
  output logic [TILE_W*BOARD_TILES-1:0]   tiles,
  output logic [TILE_W*NEXT_TILES-1:0]    next_tiles
);

  fill_state_t       state_reg, state_next;
  logic [7:0]        fill_cnt_reg, fill_cnt_next;
  logic [7:0]        fill_byte_reg, fill_byte_next;
  logic              fill_we;

  logic [TILE_W-1:0] shadow_reg [STORE_TILES];
  logic [TILE_W-1:0] disp_reg   [STORE_TILES];

  logic              commit_pending_reg;
  logic              commit_done_reg;
  logic              wr_err_reg;
  logic              trigger;
  logic              commit_fire;
  addr_kind_t        wr_kind;

  vblank_strobe #(
    .VBLANK_LINE(VBLANK_LINE)
  ) u_vblank_strobe (
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .trigger (trigger)
  );

  assign fill_busy   = (state_reg == ST_FILL);
  assign commit_fire = trigger && commit_pending_reg && !fill_busy;
  assign wr_ready    = wr_valid && !fill_busy && !commit_fire;
  assign wr_kind     = decode_addr(wr_addr);

  always_comb begin
    state_next     = state_reg;
    fill_cnt_next  = fill_cnt_reg;
    fill_byte_next = fill_byte_reg;
    fill_we        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fill_req) begin
          state_next     = ST_FILL;
          fill_cnt_next  = 8'd0;
          fill_byte_next = fill_data;
        end
      end
      ST_FILL: begin
        fill_we = 1'b1;
        if (fill_cnt_reg == 8'(BOARD_TILES - 1)) begin
          state_next = ST_IDLE;
        end else begin
          fill_cnt_next = fill_cnt_reg + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      fill_cnt_reg  <= 8'd0;
      fill_byte_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      fill_byte_reg <= fill_byte_next;
    end
  end

  // Fill and CPU writes are mutually exclusive by arbitration, so one port suffices.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STORE_TILES; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (fill_we) begin
      shadow_reg[fill_cnt_reg] <= fill_byte_reg;
    end else if (wr_ready && (wr_kind != ADDR_INVALID)) begin
      shadow_reg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STORE_TILES; i++) begin
        disp_reg[i] <= '0;
      end
    end else if (commit_fire) begin
      for (int i = 0; i < STORE_TILES; i++) begin
        disp_reg[i] <= shadow_reg[i];
      end
    end
  end

  // A request landing in the fire cycle wins, queueing a second commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending_reg <= 1'b0;
      commit_done_reg    <= 1'b0;
      wr_err_reg         <= 1'b0;
    end else begin
      if (commit_req) begin
        commit_pending_reg <= 1'b1;
      end else if (commit_fire) begin
        commit_pending_reg <= 1'b0;
      end
      commit_done_reg <= commit_fire;
      wr_err_reg      <= wr_ready && (wr_kind == ADDR_INVALID);
    end
  end

  assign commit_pending = commit_pending_reg;
  assign commit_done    = commit_done_reg;
  assign wr_err         = wr_err_reg;

  generate
    for (genvar gi = 0; gi < BOARD_TILES; gi++) begin : g_board
      assign tiles[TILE_W*gi +: TILE_W] = disp_reg[gi];
    end
    for (genvar gi = 0; gi < NEXT_TILES; gi++) begin : g_next
      assign next_tiles[TILE_W*gi +: TILE_W] = disp_reg[NEXT_BASE + gi];
    end
  endgenerate

endmodule
